// File: rtl/adat_rx_frame_parser_param.sv
//==============================================================================
// Module      : adat_rx_frame_parser_param
// Description : Parametrised ADAT frame parser. Consumes variable-width bit
//               beats from the bit decoder, checks the separator bit of every
//               5-bit group, extracts the user nibble and NUM_CH samples, and
//               maps physical channels onto logical channel/phase for S/MUX.
//               Optional statistics counter: define ADAT_RX_PARSER_STATS_EN
//               to add o_err_frames.
//               Frame layout: 5-bit user group, then NUM_CH*NIB 5-bit groups
//               (separator first, then 4 data bits MSB first).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module adat_rx_frame_parser_param #(
  parameter int NUM_CH      = 8,
  parameter int SAMPLE_BITS = 24,
  parameter int MAX_IN      = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [MAX_IN-1:0]      i_bits,
  input  logic [2:0]             i_bit_count,
  input  logic                   i_valid,
  input  logic                   i_sync,
  input  logic [1:0]             i_smux,
`ifdef ADAT_RX_PARSER_STATS_EN
  output logic [15:0]            o_err_frames,
`endif
  output logic [3:0]             o_user,
  output logic [SAMPLE_BITS-1:0] o_data,
  output logic [2:0]             o_channel,
  output logic [1:0]             o_phase,
  output logic                   o_data_valid,
  output logic                   o_frame_done,
  output logic                   o_sep_err,
  output logic                   o_frame_err
);

  localparam int NIB = SAMPLE_BITS / 4;
  localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_USER = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]             state;
  logic                   sync_q;
  logic [2:0]             grp_q;    // position inside the current 5-bit group
  logic [NW-1:0]          nib_q;    // nibbles already collected for this sample
  logic [2:0]             ch_q;     // physical channel being assembled
  logic [SAMPLE_BITS-1:0] shift_q;

  logic sync_rise;
  logic active;
  logic illegal;
  logic accept;

  assign sync_rise = i_sync & ~sync_q;
  assign active    = sync_rise || (state == ST_USER) || (state == ST_DATA);
  assign illegal   = i_valid && (i_bit_count > 3'(MAX_IN));
  assign accept    = active && i_sync && i_valid && !illegal && (i_bit_count != 3'd0);

  // Next-state walk of the beat: bits are consumed serially, earliest first
  logic [2:0]             g;
  logic [NW-1:0]          n;
  logic [2:0]             c;
  logic [SAMPLE_BITS-1:0] sh;
  logic                   in_user;
  logic                   stop;
  logic                   sep_bad;
  logic                   user_done;
  logic [3:0]             user_val;
  logic                   smp_done;
  logic [SAMPLE_BITS-1:0] smp_val;
  logic [2:0]             smp_ch;
  logic                   last_smp;

  // Walk every valid bit of the beat through the group/nibble/channel counters
  always_comb begin
    // A sync rise restarts the frame so a coincident beat lands at bit 0
    g         = sync_rise ? 3'd0 : grp_q;
    n         = sync_rise ? '0 : nib_q;
    c         = sync_rise ? 3'd0 : ch_q;
    sh        = sync_rise ? '0 : shift_q;
    in_user   = sync_rise ? 1'b1 : (state == ST_USER);
    stop      = 1'b0;
    sep_bad   = 1'b0;
    user_done = 1'b0;
    user_val  = 4'd0;
    smp_done  = 1'b0;
    smp_val   = '0;
    smp_ch    = 3'd0;
    last_smp  = 1'b0;
    for (int k = 0; k < MAX_IN; k++) begin
      if (accept && (k < int'(i_bit_count)) && !stop) begin
        if (g == 3'd0) begin
          if (!i_bits[k]) sep_bad = 1'b1;
          g = 3'd1;
        end else begin
          sh = {sh[SAMPLE_BITS-2:0], i_bits[k]};
          if (g == 3'd4) begin
            g = 3'd0;
            if (in_user) begin
              user_done = 1'b1;
              user_val  = sh[3:0];
              in_user   = 1'b0;
            end else if (n == NW'(NIB - 1)) begin
              n        = '0;
              smp_done = 1'b1;
              smp_val  = sh;
              smp_ch   = c;
              if (c == 3'(NUM_CH - 1)) begin
                // Trailing bits of the completing beat are not frame bits
                last_smp = 1'b1;
                stop     = 1'b1;
              end else begin
                c = c + 3'd1;
              end
            end else begin
              n = n + NW'(1);
            end
          end else begin
            g = g + 3'd1;
          end
        end
      end
    end
  end

  logic [2:0] map_ch;
  logic [1:0] map_ph;

  // Physical-to-logical channel mapping; reserved mode behaves as normal
  always_comb begin
    map_ch = smp_ch;
    map_ph = 2'd0;
    case (i_smux)
      2'd1: begin
        map_ch = {1'b0, smp_ch[2:1]};
        map_ph = {1'b0, smp_ch[0]};
      end
      2'd2: begin
        map_ch = {2'b00, smp_ch[2]};
        map_ph = smp_ch[1:0];
      end
      default: ;
    endcase
  end

  // Frame state, counters and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      sync_q       <= 1'b0;
      grp_q        <= 3'd0;
      nib_q        <= '0;
      ch_q         <= 3'd0;
      shift_q      <= '0;
      o_user       <= 4'd0;
      o_data       <= '0;
      o_channel    <= 3'd0;
      o_phase      <= 2'd0;
      o_data_valid <= 1'b0;
      o_frame_done <= 1'b0;
      o_sep_err    <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      sync_q       <= i_sync;
      o_data_valid <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      if (!i_sync) begin
        state <= ST_IDLE;
      end else if (active) begin
        grp_q       <= g;
        nib_q       <= n;
        ch_q        <= c;
        shift_q     <= sh;
        o_frame_err <= illegal;
        if (sync_rise)    o_sep_err <= sep_bad;
        else if (sep_bad) o_sep_err <= 1'b1;
        if (last_smp)       state <= ST_DONE;
        else if (user_done) state <= ST_DATA;
        else if (sync_rise) state <= ST_USER;
        if (user_done) o_user <= user_val;
        if (smp_done) begin
          o_data       <= smp_val;
          o_channel    <= map_ch;
          o_phase      <= map_ph;
          o_data_valid <= 1'b1;
          o_frame_done <= last_smp;
        end
      end else if (state == ST_DONE) begin
        o_frame_err <= i_valid && (i_bit_count != 3'd0);
      end
    end
  end

`ifdef ADAT_RX_PARSER_STATS_EN
  logic had_err;
  logic had_next;
  logic sep_next;

  assign had_next = sync_rise ? illegal : (had_err | illegal);
  assign sep_next = sync_rise ? sep_bad : (o_sep_err | sep_bad);

  // Saturating count of completed frames that carried any error
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      had_err      <= 1'b0;
      o_err_frames <= 16'd0;
    end else if (i_sync && active) begin
      had_err <= had_next;
      if (last_smp && (sep_next || had_next) && (o_err_frames != 16'hFFFF))
        o_err_frames <= o_err_frames + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_adat_rx_frame_parser_param.sv
//==============================================================================
// Module      : tb_adat_rx_frame_parser_param
// Description : Scoreboard bench for adat_rx_frame_parser_param. Frames are
//               built as bit lists from random samples; expected strobes are
//               queued and checked by an independent monitor.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_adat_rx_frame_parser_param;

  localparam int NCH = 8;
  localparam int SB  = 24;
  localparam int MI  = 5;
  localparam int NIB = SB / 4;
  localparam int FRAME_BITS = 5 + NCH * NIB * 5;

  logic          clk;
  logic          i_rst;
  logic [MI-1:0] i_bits;
  logic [2:0]    i_bit_count;
  logic          i_valid;
  logic          i_sync;
  logic [1:0]    i_smux;
  logic [3:0]    o_user;
  logic [SB-1:0] o_data;
  logic [2:0]    o_channel;
  logic [1:0]    o_phase;
  logic          o_data_valid;
  logic          o_frame_done;
  logic          o_sep_err;
  logic          o_frame_err;
`ifdef ADAT_RX_PARSER_STATS_EN
  logic [15:0]   o_err_frames;
`endif

  adat_rx_frame_parser_param #(
    .NUM_CH(NCH), .SAMPLE_BITS(SB), .MAX_IN(MI)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_bits(i_bits),
    .i_bit_count(i_bit_count),
    .i_valid(i_valid),
    .i_sync(i_sync),
    .i_smux(i_smux),
`ifdef ADAT_RX_PARSER_STATS_EN
    .o_err_frames(o_err_frames),
`endif
    .o_user(o_user),
    .o_data(o_data),
    .o_channel(o_channel),
    .o_phase(o_phase),
    .o_data_valid(o_data_valid),
    .o_frame_done(o_frame_done),
    .o_sep_err(o_sep_err),
    .o_frame_err(o_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SB-1:0] data;
    logic [2:0]    ch;
    logic [1:0]    ph;
    logic          done;
  } exp_t;

  exp_t          expq[$];
  bit            fb[$];
  logic [SB-1:0] smp[0:NCH-1];
  int            vectors    = 0;
  int            miscompares = 0;
  int            ferr_cnt   = 0;
  int            exp_ferr   = 0;
  logic [3:0]    last_user  = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_user"},  32'(o_user), 0);
    check({tag, "_data"},  32'(o_data), 0);
    check({tag, "_chan"},  32'(o_channel), 0);
    check({tag, "_phase"}, 32'(o_phase), 0);
    check({tag, "_valid"}, 32'(o_data_valid), 0);
    check({tag, "_done"},  32'(o_frame_done), 0);
    check({tag, "_sep"},   32'(o_sep_err), 0);
    check({tag, "_ferr"},  32'(o_frame_err), 0);
  endtask

  // Monitor: pops the scoreboard on every data strobe
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (o_frame_err) ferr_cnt++;
      if (o_data_valid) begin
        if (expq.size() == 0) begin
          check("strobe_unexpected", 32'(o_data_valid), 0);
        end else begin
          e = expq.pop_front();
          check("data",  32'(o_data), 32'(e.data));
          check("chan",  32'(o_channel), 32'(e.ch));
          check("phase", 32'(o_phase), 32'(e.ph));
          check("done",  32'(o_frame_done), 32'(e.done));
        end
      end else if (o_frame_done) begin
        check("done_alone", 32'(o_frame_done), 0);
      end
    end
  end

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && expq.size() != 0; i++) @(negedge clk);
    check({tag, "_drain"}, 32'(expq.size()), 0);
  endtask

  // abort: 0 = complete frame, 1 = drop sync after limit bits, 2 = reset
  task automatic send_frame(input logic [3:0] u, input logic [1:0] smux,
                            input int beat_fixed, input int bad_pos, input int limit,
                            input int abort, input bit inj, input bit extra);
    int pos, n, r, eb, lch, lph;
    bit user_chk, sep_chk, sep_exp, injected, first;
    logic [MI-1:0] bv;
    exp_t e;
    fb.delete();
    fb.push_back(1'b1);
    for (int b = 3; b >= 0; b--) fb.push_back(u[b]);
    for (int p = 0; p < NCH; p++)
      for (int j = NIB - 1; j >= 0; j--) begin
        fb.push_back(1'b1);
        for (int b = 3; b >= 0; b--) fb.push_back(smp[p][4*j+b]);
      end
    if (bad_pos >= 0) fb[bad_pos] = 1'b0;
    for (int p = 0; p < NCH; p++) begin
      eb = 5 + (p + 1) * NIB * 5;
      if (smux == 2'd1)      begin lch = p / 2; lph = p % 2; end
      else if (smux == 2'd2) begin lch = p / 4; lph = p % 4; end
      else                   begin lch = p;     lph = 0;     end
      if (eb <= limit) begin
        e.data = smp[p]; e.ch = 3'(lch); e.ph = 2'(lph); e.done = (p == NCH - 1);
        expq.push_back(e);
      end
    end
    sep_exp = (bad_pos >= 0) && (bad_pos < limit);

    @(negedge clk);
    i_sync = 1'b0; i_valid = 1'b0; i_smux = smux;
    @(negedge clk);
    pos = 0; first = 1; injected = 0; user_chk = 0; sep_chk = 0;
    while (pos < limit) begin
      @(negedge clk);
      if (user_chk) check("user_early", 32'(o_user), 32'(u));
      if (sep_chk)  check("sep_early", 32'(o_sep_err), 1);
      user_chk = 0; sep_chk = 0;
      i_sync = 1'b1;
      r = $urandom_range(0, 15);
      if (!first && r == 0) begin
        i_valid = 1'b0;
      end else if (!first && r == 1) begin
        i_valid = 1'b1; i_bit_count = 3'd0; i_bits = MI'($urandom);
      end else if (!first && inj && !injected && pos >= 50) begin
        i_valid = 1'b1; i_bit_count = 3'd6; i_bits = MI'($urandom);
        injected = 1; exp_ferr++;
      end else begin
        n = (beat_fixed != 0) ? beat_fixed : $urandom_range(1, MI);
        if (n > limit - pos) n = limit - pos;
        bv = MI'($urandom);
        for (int k = 0; k < n; k++) bv[k] = fb[pos+k];
        if (pos < 5 && pos + n >= 5) user_chk = 1;
        if (bad_pos >= pos && bad_pos < pos + n) sep_chk = 1;
        i_valid = 1'b1; i_bits = bv; i_bit_count = 3'(n);
        pos += n;
      end
      first = 0;
    end
    @(negedge clk);
    i_valid = 1'b0;
    if (user_chk) check("user_early", 32'(o_user), 32'(u));
    if (sep_chk)  check("sep_early", 32'(o_sep_err), 1);

    if (abort == 0) begin
      wait_drain("frame");
      check("user_end", 32'(o_user), 32'(u));
      check("sep_end", 32'(o_sep_err), 32'(sep_exp));
      if (extra) begin
        @(negedge clk);
        i_valid = 1'b1; i_bit_count = 3'd5; i_bits = MI'($urandom);
        exp_ferr++;
        @(negedge clk);
        i_valid = 1'b0;
        check("ferr_pulse", 32'(o_frame_err), 1);
        check("done_no_strobe", 32'(o_data_valid), 0);
        @(negedge clk);
        check("ferr_once", 32'(o_frame_err), 0);
      end
      last_user = u;
    end else if (abort == 1) begin
      i_sync = 1'b0;
      @(negedge clk);
      @(negedge clk);
      wait_drain("partial");
      if (limit >= 5) last_user = u;
      check("user_kept", 32'(o_user), 32'(last_user));
    end else begin
      #2 i_rst = 1'b1;
      #1 check_zero("midrst");
      check("midrst_q", 32'(expq.size()), 0);
      i_sync = 1'b0;
      @(negedge clk);
      i_rst = 1'b0;
      last_user = 4'd0;
    end
    check("ferr_count", 32'(ferr_cnt), 32'(exp_ferr));
  endtask

  task automatic rand_samples();
    for (int p = 0; p < NCH; p++) smp[p] = SB'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_bits = '0; i_bit_count = 3'd0; i_valid = 1'b0;
    i_sync = 1'b0; i_smux = 2'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    i_rst = 1'b0;

    // User nibble A and known ch0/ch1 samples, 5-bit then 3-bit beats
    rand_samples();
    smp[0] = 24'h123456; smp[1] = 24'hFFFFFF;
    send_frame(4'hA, 2'd0, 5, -1, FRAME_BITS, 0, 0, 0);
    send_frame(4'hA, 2'd0, 3, -1, FRAME_BITS, 0, 0, 0);

    // S/MUX4 with an extra beat after the frame completes
    rand_samples();
    send_frame(4'h5, 2'd2, 0, -1, FRAME_BITS, 0, 0, 1);

    // S/MUX2, bad separator in ch3 group 2, illegal bit count mid-frame
    rand_samples();
    send_frame(4'h3, 2'd1, 0, 5 + 3 * NIB * 5 + 2 * 5, FRAME_BITS, 0, 1, 0);

    // Reserved S/MUX mode, clean frame clears the sticky separator error
    rand_samples();
    send_frame(4'hC, 2'd3, 0, -1, FRAME_BITS, 0, 0, 0);

    // Partial frame dropped after 100 bits, then a full frame
    rand_samples();
    send_frame(4'h9, 2'd0, 0, -1, 100, 1, 0, 0);
    rand_samples();
    send_frame(4'h6, 2'd0, 0, -1, FRAME_BITS, 0, 0, 0);

    // Asynchronous reset mid-frame, then recovery
    rand_samples();
    send_frame(4'hE, 2'd2, 0, -1, 60, 2, 0, 0);
    rand_samples();
    send_frame(4'h1, 2'd1, 0, -1, FRAME_BITS, 0, 0, 0);

    // Random frames
    for (int f = 0; f < 6; f++) begin
      rand_samples();
      send_frame(4'($urandom), 2'($urandom),
                 0, ($urandom_range(0, 1) == 1) ? 5 * $urandom_range(0, NCH * NIB) : -1,
                 FRAME_BITS, 0, 1'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
